halloween_opcode_executor: RTL and testbench
============================================

// Module: halloween_opcode_executor
// PURPOSE
//  Consumer end of the decoration opcode path: takes one 4-bit opcode per
//    valid/ready handshake from the opcode selector.
//  Decodes class[3:2] (00 system, 01 colour, 10 sound, 11 effect) and op[1:0].
//  Drives the decoration's lamp colour, sound player and movement/fog actuators.
//  Runs timed sound/effect actions to completion before accepting the next opcode.
// PARAMETERS
//  SOUND_CYCLES         8   cycles a sound output stays active (>=1)
//  EFFECT_CYCLES        16  cycles an effect output stays active (>=1)
//  FOG_COOLDOWN_CYCLES  4   extra dead cycles after FOG (only with FOG_COOLDOWN_EN)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  op_valid     in   1  op_code valid this cycle
//  op_code      in   4  {class[1:0], op[1:0]}
//  op_ready     out  1  executor can accept; transfer = op_valid & op_ready at posedge
//  powered      out  1  decoration is ON
//  color        out  2  00 green, 01 purple, 10 orange, 11 dark
//  sound_on     out  1  sound playing
//  sound_sel    out  2  00 scream, 01 cackle, 10 boo (valid while sound_on)
//  wave_hands   out  1  hand actuator active
//  move_jaw     out  1  jaw actuator active
//  fog          out  1  fog machine active
//  illegal_op   out  1  one-cycle pulse: accepted opcode was undefined
// BEHAVIOUR
//  All outputs registered. Reset values: powered=0, color=11, sound_on=0, sound_sel=00,
//    wave_hands/move_jaw/fog=0, illegal_op=0, state=S_OFF, timer=0.
//  op_ready is combinational from state only: 1 in S_OFF/S_IDLE, 0 in S_SOUND/S_EFFECT/S_COOL.
//  Accepted opcode at edge k -> outputs change at edge k (visible cycle k+1).
//  Undefined codes: 0010,0011,0111,1011,1111 -> illegal_op=1 for one cycle, no other change.
//  S_OFF: 0000 ON -> powered=1, S_IDLE; every other opcode is consumed silently (no illegal_op,
//    no change); 0001 RESET is a no-op.
//  S_IDLE:
//    0000 ON -> no-op.
//    0001 RESET -> all outputs to reset values, S_OFF.
//    01xx -> color=op; stay in S_IDLE.
//    10xx -> sound_on=1, sound_sel=op, timer=SOUND_CYCLES-1, S_SOUND.
//    11xx -> the matching actuator=1, timer=EFFECT_CYCLES-1, S_EFFECT.
//  S_SOUND/S_EFFECT: timer decrements each cycle.
//    At timer==0: clear the active output and return to S_IDLE (or S_COOL after FOG when enabled).
//    Active output is high for exactly N cycles.
//  Colour persists through sound/effect; only RESET or rst restores dark.
//  rst mid-action: aborts immediately, all outputs to reset values next cycle; the in-flight
//    handshake is ignored.
//  op_valid with op_ready=0: no transfer; upstream must hold.
// CONFIGURATION
//  FOG_COOLDOWN_EN defined:
//    After FOG completes -> S_COOL for FOG_COOLDOWN_CYCLES cycles, op_ready=0, all actuators 0;
//      then S_IDLE.
//  FOG_COOLDOWN_EN undefined:
//    S_COOL and FOG_COOLDOWN_CYCLES are unused; FOG returns directly to S_IDLE like other effects.
// STRUCTURE
//  halloween_pkg:
//    Opcode constants OP_ON..OP_FOG.
//    Class constants CLS_SYS/CLS_COLOR/CLS_SOUND/CLS_EFFECT.
//    Colour codes incl. COLOR_DARK.
//    State encoding S_OFF/S_IDLE/S_SOUND/S_EFFECT/S_COOL.
//  Sub-module hd_action_timer: loadable down-counter (load, load_val, done), shared by all timed states.
// TESTING
//  1 Power-up: rst 2 cycles, then 0100 in S_OFF -> no change, no illegal_op; then 0000
//    -> powered=1, op_ready=1, color=11.
//  2 Colour: 0110 -> color=10 next cycle, op_ready stays 1.
//  3 Sound: 1001 -> sound_on=1, sound_sel=01 for exactly 8 cycles; op_ready=0 throughout;
//    a held 1010 is accepted on the first cycle op_ready returns to 1.
//  4 Illegal: 1111 in S_IDLE -> illegal_op high one cycle; no other outputs change.
//  5 Abort: 1100 in S_IDLE, assert rst on the 5th active cycle -> wave_hands=0, powered=0,
//    color=11 next cycle.
//  6 Fog: 1110 -> fog high 16 cycles; op_ready=0 for 16+4 cycles with FOG_COOLDOWN_EN,
//    16 cycles without it.

Source files
------------

// File: rtl/halloween_pkg.sv
// Shared opcode, class, colour and state encodings for the decoration executor.
package halloween_pkg;

   // Full 4-bit opcodes {class, op}
   localparam logic [3:0] OP_ON     = 4'b0000;
   localparam logic [3:0] OP_RESET  = 4'b0001;
   localparam logic [3:0] OP_GREEN  = 4'b0100;
   localparam logic [3:0] OP_PURPLE = 4'b0101;
   localparam logic [3:0] OP_ORANGE = 4'b0110;
   localparam logic [3:0] OP_SCREAM = 4'b1000;
   localparam logic [3:0] OP_CACKLE = 4'b1001;
   localparam logic [3:0] OP_BOO    = 4'b1010;
   localparam logic [3:0] OP_WAVE   = 4'b1100;
   localparam logic [3:0] OP_JAW    = 4'b1101;
   localparam logic [3:0] OP_FOG    = 4'b1110;

   // Opcode classes (op_code[3:2])
   localparam logic [1:0] CLS_SYS    = 2'b00;
   localparam logic [1:0] CLS_COLOR  = 2'b01;
   localparam logic [1:0] CLS_SOUND  = 2'b10;
   localparam logic [1:0] CLS_EFFECT = 2'b11;

   // Lamp colours
   localparam logic [1:0] COLOR_GREEN  = 2'b00;
   localparam logic [1:0] COLOR_PURPLE = 2'b01;
   localparam logic [1:0] COLOR_ORANGE = 2'b10;
   localparam logic [1:0] COLOR_DARK   = 2'b11;

   // Executor states
   localparam logic [2:0] S_OFF    = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_SOUND  = 3'd2;
   localparam logic [2:0] S_EFFECT = 3'd3;
   localparam logic [2:0] S_COOL   = 3'd4;

   // Codes with no defined meaning in the opcode map
   function automatic logic op_is_undefined(input logic [3:0] code);
      case (code)
         4'b0010, 4'b0011, 4'b0111, 4'b1011, 4'b1111: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hd_action_timer.sv
// Loadable down-counter shared by all timed executor states; done while count is zero.
module hd_action_timer #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // Load has priority; otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (rst)             cnt <= '0;
      else if (load)       cnt <= load_val;
      else if (cnt != '0)  cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/halloween_opcode_executor.sv
// Decoration opcode executor: decodes one opcode per handshake and drives lamp,
// sound and actuator outputs, holding off new opcodes while a timed action runs.
// Optional build macro: FOG_COOLDOWN_EN adds a dead period after FOG.
module halloween_opcode_executor
   import halloween_pkg::*;
#(
   parameter int unsigned SOUND_CYCLES        = 8,
   parameter int unsigned EFFECT_CYCLES       = 16,
   parameter int unsigned FOG_COOLDOWN_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   input  logic [3:0] op_code,
   output logic       op_ready,
   output logic       powered,
   output logic [1:0] color,
   output logic       sound_on,
   output logic [1:0] sound_sel,
   output logic       wave_hands,
   output logic       move_jaw,
   output logic       fog,
   output logic       illegal_op
);

   localparam int unsigned MAX_SE  = (SOUND_CYCLES > EFFECT_CYCLES) ? SOUND_CYCLES : EFFECT_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_SE > FOG_COOLDOWN_CYCLES) ? MAX_SE : FOG_COOLDOWN_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);

   logic [2:0]    state, state_d;
   logic          powered_d, sound_on_d, wave_d, jaw_d, fog_d, illegal_d;
   logic [1:0]    color_d, sel_d;
   logic          tmr_load, tmr_done;
   logic [TW-1:0] tmr_val;
   logic          accept;

   assign op_ready = (state == S_OFF) || (state == S_IDLE);
   assign accept   = op_valid && op_ready;

   hd_action_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Next-state and next-output decode
   always_comb begin
      state_d    = state;
      powered_d  = powered;
      color_d    = color;
      sound_on_d = sound_on;
      sel_d      = sound_sel;
      wave_d     = wave_hands;
      jaw_d      = move_jaw;
      fog_d      = fog;
      illegal_d  = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      case (state)
         S_OFF: begin
            // Only ON wakes the decoration; everything else is swallowed
            if (accept && op_code == OP_ON) begin
               powered_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_IDLE: begin
            if (accept) begin
               if (op_is_undefined(op_code)) begin
                  illegal_d = 1'b1;
               end else begin
                  case (op_code[3:2])
                     CLS_SYS: begin
                        if (op_code == OP_RESET) begin
                           powered_d  = 1'b0;
                           color_d    = COLOR_DARK;
                           sound_on_d = 1'b0;
                           sel_d      = 2'b00;
                           wave_d     = 1'b0;
                           jaw_d      = 1'b0;
                           fog_d      = 1'b0;
                           state_d    = S_OFF;
                        end
                     end
                     CLS_COLOR: color_d = op_code[1:0];
                     CLS_SOUND: begin
                        sound_on_d = 1'b1;
                        sel_d      = op_code[1:0];
                        tmr_load   = 1'b1;
                        tmr_val    = TW'(SOUND_CYCLES - 1);
                        state_d    = S_SOUND;
                     end
                     CLS_EFFECT: begin
                        case (op_code[1:0])
                           2'b00:   wave_d = 1'b1;
                           2'b01:   jaw_d  = 1'b1;
                           default: fog_d  = 1'b1;
                        endcase
                        tmr_load = 1'b1;
                        tmr_val  = TW'(EFFECT_CYCLES - 1);
                        state_d  = S_EFFECT;
                     end
                  endcase
               end
            end
         end
         S_SOUND: begin
            if (tmr_done) begin
               sound_on_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         S_EFFECT: begin
            if (tmr_done) begin
               wave_d  = 1'b0;
               jaw_d   = 1'b0;
               fog_d   = 1'b0;
               state_d = S_IDLE;
`ifdef FOG_COOLDOWN_EN
               // Let the fog machine rest before any further opcode
               if (fog) begin
                  tmr_load = 1'b1;
                  tmr_val  = TW'(FOG_COOLDOWN_CYCLES - 1);
                  state_d  = S_COOL;
               end
`endif
            end
         end
         S_COOL: begin
            if (tmr_done) state_d = S_IDLE;
         end
         default: state_d = S_OFF;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_OFF;
         powered    <= 1'b0;
         color      <= COLOR_DARK;
         sound_on   <= 1'b0;
         sound_sel  <= 2'b00;
         wave_hands <= 1'b0;
         move_jaw   <= 1'b0;
         fog        <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state      <= state_d;
         powered    <= powered_d;
         color      <= color_d;
         sound_on   <= sound_on_d;
         sound_sel  <= sel_d;
         wave_hands <= wave_d;
         move_jaw   <= jaw_d;
         fog        <= fog_d;
         illegal_op <= illegal_d;
      end
   end

endmodule

// File: tb/tb_halloween_opcode_executor.sv
// Self-checking bench for halloween_opcode_executor: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_halloween_opcode_executor;

   localparam int SOUND_N  = 8;
   localparam int EFFECT_N = 16;
`ifdef FOG_COOLDOWN_EN
   localparam int COOL_N   = 4;
`else
   localparam int COOL_N   = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       op_valid = 1'b0;
   logic [3:0] op_code = 4'b0000;
   logic       op_ready, powered, sound_on, wave_hands, move_jaw, fog, illegal_op;
   logic [1:0] color, sound_sel;

   always #5 clk = ~clk;

   halloween_opcode_executor dut (
      .clk        (clk),
      .rst        (rst),
      .op_valid   (op_valid),
      .op_code    (op_code),
      .op_ready   (op_ready),
      .powered    (powered),
      .color      (color),
      .sound_on   (sound_on),
      .sound_sel  (sound_sel),
      .wave_hands (wave_hands),
      .move_jaw   (move_jaw),
      .fog        (fog),
      .illegal_op (illegal_op)
   );

   logic [10:0] dut_vec;
   assign dut_vec = {op_ready, powered, color, sound_on, sound_sel,
                     wave_hands, move_jaw, fog, illegal_op};

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: remaining-cycle counters instead of states
   logic       m_powered, m_sound_on, m_wave, m_jaw, m_fog, m_ill;
   logic [1:0] m_color, m_sel;
   int         m_act, m_cool;

   function automatic logic [10:0] model_vec();
      return {(m_act == 0 && m_cool == 0), m_powered, m_color, m_sound_on, m_sel,
              m_wave, m_jaw, m_fog, m_ill};
   endfunction

   task automatic model_reset();
      m_powered = 1'b0; m_color = 2'b11; m_sound_on = 1'b0; m_sel = 2'b00;
      m_wave = 1'b0; m_jaw = 1'b0; m_fog = 1'b0; m_ill = 1'b0;
      m_act = 0; m_cool = 0;
   endtask

   task automatic model_step(input logic r, input logic v, input logic [3:0] c);
      bit ready;
      ready = (m_act == 0 && m_cool == 0);
      if (r) begin
         model_reset();
         return;
      end
      m_ill = 1'b0;
      if (m_act > 0) begin
         m_act--;
         if (m_act == 0) begin
            if (m_fog && COOL_N > 0) m_cool = COOL_N;
            m_sound_on = 1'b0; m_wave = 1'b0; m_jaw = 1'b0; m_fog = 1'b0;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (v && ready) begin
         if (!m_powered) begin
            if (c == 4'b0000) m_powered = 1'b1;
         end else if (c inside {4'b0010, 4'b0011, 4'b0111, 4'b1011, 4'b1111}) begin
            m_ill = 1'b1;
         end else if (c == 4'b0001) begin
            model_reset();
         end else if (c[3:2] == 2'b01) begin
            m_color = c[1:0];
         end else if (c[3:2] == 2'b10) begin
            m_sound_on = 1'b1; m_sel = c[1:0]; m_act = SOUND_N;
         end else if (c[3:2] == 2'b11) begin
            m_act = EFFECT_N;
            case (c[1:0])
               2'b00:   m_wave = 1'b1;
               2'b01:   m_jaw  = 1'b1;
               default: m_fog  = 1'b1;
            endcase
         end
      end
   endtask

   // Drive one cycle of inputs (called just after a falling edge), advance the
   // model across the rising edge, and return at the next falling edge.
   task automatic tick(input logic r, input logic v, input logic [3:0] c);
      rst = r; op_valid = v; op_code = c;
      model_step(r, v, c);
      @(negedge clk);
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 4'b0000);
      tick(1'b1, 1'b0, 4'b0000);
      n_cmp++; if (dut_vec !== 11'b1_0_11_0_00_000_0) begin n_fail++;
         $display("FAIL reset_values got=%b exp=%b", dut_vec, 11'b1_0_11_0_00_000_0); end
      tick(1'b0, 1'b1, 4'b0100);
      n_cmp++; if (dut_vec !== 11'b1_0_11_0_00_000_0) begin n_fail++;
         $display("FAIL off_ignores_color got=%b exp=%b", dut_vec, 11'b1_0_11_0_00_000_0); end
      tick(1'b0, 1'b1, 4'b0000);
      n_cmp++; if ({powered, op_ready, color, illegal_op} !== 5'b1_1_11_0) begin n_fail++;
         $display("FAIL power_on got=%b exp=%b", {powered, op_ready, color, illegal_op}, 5'b11110); end
   endtask

   task automatic test_color();
      tick(1'b0, 1'b1, 4'b0110);
      n_cmp++; if ({color, op_ready} !== 3'b10_1) begin n_fail++;
         $display("FAIL color_orange got=%b exp=%b", {color, op_ready}, 3'b101); end
   endtask

   task automatic test_sound();
      int n;
      bit bad;
      n = 0; bad = 0;
      tick(1'b0, 1'b1, 4'b1001);
      for (int i = 0; i < 20; i++) begin
         if (sound_on !== 1'b1) break;
         if (op_ready !== 1'b0 || sound_sel !== 2'b01) bad = 1;
         n++;
         tick(1'b0, 1'b1, 4'b1010);
      end
      n_cmp++; if (n !== SOUND_N) begin n_fail++;
         $display("FAIL sound_duration got=%0d exp=%0d", n, SOUND_N); end
      n_cmp++; if (bad !== 1'b0) begin n_fail++;
         $display("FAIL sound_busy_ready_sel got=%b exp=0", bad); end
      n_cmp++; if (op_ready !== 1'b1) begin n_fail++;
         $display("FAIL sound_ready_return got=%b exp=1", op_ready); end
      tick(1'b0, 1'b1, 4'b1010);
      n_cmp++; if ({sound_on, sound_sel, color} !== 5'b1_10_10) begin n_fail++;
         $display("FAIL held_boo_accepted got=%b exp=%b", {sound_on, sound_sel, color}, 5'b11010); end
      for (int i = 0; i < 40 && op_ready !== 1'b1; i++) tick(1'b0, 1'b0, 4'b0000);
      n_cmp++; if (op_ready !== 1'b1) begin n_fail++;
         $display("FAIL sound_drain_timeout got=%b exp=1", op_ready); end
   endtask

   task automatic test_illegal();
      tick(1'b0, 1'b1, 4'b1111);
      n_cmp++; if ({illegal_op, color, powered, op_ready} !== 5'b1_10_1_1) begin n_fail++;
         $display("FAIL illegal_pulse got=%b exp=%b", {illegal_op, color, powered, op_ready}, 5'b11011); end
      n_cmp++; if (dut_vec !== model_vec()) begin n_fail++;
         $display("FAIL illegal_vs_model got=%b exp=%b", dut_vec, model_vec()); end
      tick(1'b0, 1'b0, 4'b0000);
      n_cmp++; if (illegal_op !== 1'b0) begin n_fail++;
         $display("FAIL illegal_one_cycle got=%b exp=0", illegal_op); end
   endtask

   task automatic test_abort();
      int n;
      n = 0;
      tick(1'b0, 1'b1, 4'b1100);
      if (wave_hands === 1'b1) n++;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 4'b0000);
         if (wave_hands === 1'b1) n++;
      end
      n_cmp++; if (n !== 5) begin n_fail++;
         $display("FAIL abort_wave_active got=%0d exp=5", n); end
      tick(1'b1, 1'b1, 4'b0110);
      n_cmp++; if (dut_vec !== 11'b1_0_11_0_00_000_0) begin n_fail++;
         $display("FAIL abort_reset got=%b exp=%b", dut_vec, 11'b1_0_11_0_00_000_0); end
   endtask

   task automatic test_fog();
      int n_fog, n_busy;
      bit  done;
      n_fog = 0; n_busy = 0; done = 0;
      tick(1'b0, 1'b1, 4'b0000);
      tick(1'b0, 1'b1, 4'b1110);
      for (int i = 0; i < 80; i++) begin
         if (op_ready === 1'b1) begin done = 1; break; end
         if (fog === 1'b1) n_fog++;
         n_busy++;
         tick(1'b0, 1'b0, 4'b0000);
      end
      n_cmp++; if (done !== 1'b1) begin n_fail++;
         $display("FAIL fog_timeout got=%b exp=1", done); end
      n_cmp++; if (n_fog !== EFFECT_N) begin n_fail++;
         $display("FAIL fog_duration got=%0d exp=%0d", n_fog, EFFECT_N); end
      n_cmp++; if (n_busy !== EFFECT_N + COOL_N) begin n_fail++;
         $display("FAIL fog_busy got=%0d exp=%0d", n_busy, EFFECT_N + COOL_N); end
   endtask

   task automatic test_random();
      logic       r, v;
      logic [3:0] c;
      int         bad;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 63) == 0);
         v = 1'($urandom_range(0, 1));
         c = (!m_powered && $urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
         tick(r, v, c);
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++;
            if (bad < 10) $display("FAIL random_cycle_%0d got=%b exp=%b", i, dut_vec, model_vec());
            bad++;
         end
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_color();
      test_sound();
      test_illegal();
      test_abort();
      test_fog();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
